// File: rtl/median3x3_stream.sv
// Streaming 3x3 per-channel median filter with two line buffers and a 3-stage compare network.
// Define MEDIAN_BYPASS_EN to add i_bypass, which selects the window centre tap instead of the median.
module median3x3_stream #(
  parameter int CH_W   = 4,
  parameter int NUM_CH = 3,
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_valid,
  input  logic                     i_sof,
  input  logic [NUM_CH*CH_W-1:0]   i_data,
`ifdef MEDIAN_BYPASS_EN
  input  logic                     i_bypass,
`endif
  output logic                     o_valid,
  output logic                     o_sof,
  output logic                     o_eol,
  output logic [NUM_CH*CH_W-1:0]   o_data
);

  localparam int DATA_W = NUM_CH * CH_W;
  localparam int XW     = $clog2(IMG_W);
  localparam int YW     = $clog2(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  typedef logic [CH_W-1:0]   ch_t;
  typedef logic [DATA_W-1:0] pix_t;

  function automatic ch_t min2(input ch_t a, input ch_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic ch_t max2(input ch_t a, input ch_t b);
    return (a < b) ? b : a;
  endfunction

  function automatic ch_t min3(input ch_t a, input ch_t b, input ch_t c);
    return min2(min2(a, b), c);
  endfunction

  function automatic ch_t max3(input ch_t a, input ch_t b, input ch_t c);
    return max2(max2(a, b), c);
  endfunction

  function automatic ch_t med3(input ch_t a, input ch_t b, input ch_t c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  logic [XW-1:0] x, pos_x;
  logic [YW-1:0] y, pos_y;
  logic          byp_in;

`ifdef MEDIAN_BYPASS_EN
  assign byp_in = i_bypass;
`else
  assign byp_in = 1'b0;
`endif

  // i_sof overrides the counters so a frame start always resynchronises to (0,0)
  always_comb begin
    pos_x = x;
    pos_y = y;
    if (i_sof) begin
      pos_x = '0;
      pos_y = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (i_valid) begin
      if (pos_x == X_LAST) begin
        x <= '0;
        y <= (pos_y == Y_LAST) ? '0 : pos_y + YW'(1);
      end else begin
        x <= pos_x + XW'(1);
        y <= pos_y;
      end
    end
  end

  // ---- stage p0: line buffers and window (row 0 oldest line, column 2 newest pixel)
  pix_t lb0 [IMG_W];
  pix_t lb1 [IMG_W];
  pix_t win [3][3];
  logic vld_p0, sof_p0, eol_p0, bord_p0, byp_p0;

  always_ff @(posedge clk) begin
    if (i_valid) begin
      lb1[pos_x] <= lb0[pos_x];
      lb0[pos_x] <= i_data;
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb1[pos_x];
      win[1][2] <= lb0[pos_x];
      win[2][2] <= i_data;
    end
    bord_p0 <= (pos_x < XW'(2)) || (pos_y < YW'(2));
    byp_p0  <= byp_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      sof_p0 <= 1'b0;
      eol_p0 <= 1'b0;
    end else begin
      vld_p0 <= i_valid;
      sof_p0 <= i_valid && (pos_x == '0) && (pos_y == '0);
      eol_p0 <= i_valid && (pos_x == X_LAST);
    end
  end

  // ---- stage p1: sort each column into min/mid/max
  pix_t lo_p1 [3];
  pix_t mid_p1 [3];
  pix_t hi_p1 [3];
  pix_t ctr_p1;
  logic vld_p1, sof_p1, eol_p1, bord_p1, byp_p1;

  always_ff @(posedge clk) begin
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        lo_p1[c][k*CH_W +: CH_W]  <= min3(win[0][c][k*CH_W +: CH_W], win[1][c][k*CH_W +: CH_W],
                                          win[2][c][k*CH_W +: CH_W]);
        mid_p1[c][k*CH_W +: CH_W] <= med3(win[0][c][k*CH_W +: CH_W], win[1][c][k*CH_W +: CH_W],
                                          win[2][c][k*CH_W +: CH_W]);
        hi_p1[c][k*CH_W +: CH_W]  <= max3(win[0][c][k*CH_W +: CH_W], win[1][c][k*CH_W +: CH_W],
                                          win[2][c][k*CH_W +: CH_W]);
      end
    end
    ctr_p1  <= win[1][1];
    bord_p1 <= bord_p0;
    byp_p1  <= byp_p0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      sof_p1 <= 1'b0;
      eol_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      sof_p1 <= sof_p0;
      eol_p1 <= eol_p0;
    end
  end

  // ---- stage p2: max of mins, median of mids, min of maxes
  pix_t lo_max_p2, mid_med_p2, hi_min_p2, ctr_p2;
  logic vld_p2, sof_p2, eol_p2, bord_p2, byp_p2;

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      lo_max_p2[k*CH_W +: CH_W]  <= max3(lo_p1[0][k*CH_W +: CH_W], lo_p1[1][k*CH_W +: CH_W],
                                         lo_p1[2][k*CH_W +: CH_W]);
      mid_med_p2[k*CH_W +: CH_W] <= med3(mid_p1[0][k*CH_W +: CH_W], mid_p1[1][k*CH_W +: CH_W],
                                         mid_p1[2][k*CH_W +: CH_W]);
      hi_min_p2[k*CH_W +: CH_W]  <= min3(hi_p1[0][k*CH_W +: CH_W], hi_p1[1][k*CH_W +: CH_W],
                                         hi_p1[2][k*CH_W +: CH_W]);
    end
    ctr_p2  <= ctr_p1;
    bord_p2 <= bord_p1;
    byp_p2  <= byp_p1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p2 <= 1'b0;
      sof_p2 <= 1'b0;
      eol_p2 <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      sof_p2 <= sof_p1;
      eol_p2 <= eol_p1;
    end
  end

  // ---- stage p3: final median, border zeroing, output register
  pix_t med_p2, res_p2;

  always_comb begin
    med_p2 = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      med_p2[k*CH_W +: CH_W] = med3(lo_max_p2[k*CH_W +: CH_W], mid_med_p2[k*CH_W +: CH_W],
                                    hi_min_p2[k*CH_W +: CH_W]);
    end
    res_p2 = bord_p2 ? '0 : (byp_p2 ? ctr_p2 : med_p2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_valid <= 1'b0;
      o_sof   <= 1'b0;
      o_eol   <= 1'b0;
      o_data  <= '0;
    end else begin
      o_valid <= vld_p2;
      o_sof   <= sof_p2;
      o_eol   <= eol_p2;
      if (vld_p2) o_data <= res_p2;
    end
  end

endmodule

// File: tb/tb_median3x3_stream.sv
// Scoreboard bench for median3x3_stream on an 8x6 image with 3 x 4-bit channels.
module tb_median3x3_stream;
  localparam int CH_W   = 4;
  localparam int NUM_CH = 3;
  localparam int IMG_W  = 8;
  localparam int IMG_H  = 6;

  logic        clk = 1'b0;
  logic        reset, i_valid, i_sof;
  logic [11:0] i_data;
`ifdef MEDIAN_BYPASS_EN
  logic        i_bypass;
`endif
  logic        o_valid, o_sof, o_eol;
  logic [11:0] o_data;

  median3x3_stream #(.CH_W(CH_W), .NUM_CH(NUM_CH), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_sof(i_sof), .i_data(i_data),
`ifdef MEDIAN_BYPASS_EN
    .i_bypass(i_bypass),
`endif
    .o_valid(o_valid), .o_sof(o_sof), .o_eol(o_eol), .o_data(o_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] data;
    logic        sof;
    logic        eol;
    int          stamp;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [11:0] last_data = 12'h000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: sample 1 time unit after each rising edge
  always @(posedge clk) begin
    #1;
    if (reset) begin
      last_data = 12'h000;
    end else if (o_valid) begin
      check("queue_nonempty", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        check("data", o_data, e.data);
        check("flags", {o_sof, o_eol}, {e.sof, e.eol});
        check("latency", cyc, e.stamp + 3);
      end
      last_data = o_data;
    end else begin
      check("idle_hold", {o_sof, o_eol, o_data}, {2'b00, last_data});
    end
  end

  function automatic logic [11:0] pix(input int t, input int x, input int y);
    int v;
    v = (y % 3) * 3 + (x % 3);
    case (t)
      1: return 12'h5A3;
      2: return (x == 4 && y == 3) ? 12'hFFF : 12'h000;
      3: return (x < 4) ? 12'h111 : 12'h999;
      default: return {4'(v + 1), 4'(9 - v), 4'h7};
    endcase
  endfunction

  // Hand-derived expected outputs for the input at (x,y)
  function automatic logic [11:0] expv(input int t, input int x, input int y);
    if (x < 2 || y < 2) return 12'h000;
    case (t)
      1: return 12'h5A3;
      2: return 12'h000;
      3: return (x <= 4) ? 12'h111 : 12'h999;
      4: return 12'h557;
      default: return (x == 5 && y == 4) ? 12'hFFF : 12'h000;
    endcase
  endfunction

  task automatic drive(input logic [11:0] d, input logic s, input logic [11:0] ed,
                       input logic es, input logic ee);
    exp_t e;
    @(negedge clk);
    i_valid = 1'b1;
    i_sof   = s;
    i_data  = d;
    e.data  = ed;
    e.sof   = es;
    e.eol   = ee;
    e.stamp = cyc + 1;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      i_valid = 1'b0;
      i_sof   = 1'b0;
      i_data  = 12'hABC;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    i_valid = 1'b0;
    i_sof   = 1'b0;
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    check("rst_valid", o_valid, 1'b0);
    check("rst_data", o_data, 12'h000);
    check("rst_flags", {o_sof, o_eol}, 2'b00);
  endtask

  task automatic frame(input int t, input int et, input bit gaps, input int stop_at);
    for (int y = 0; y < IMG_H; y++) begin
      for (int x = 0; x < IMG_W; x++) begin
        if (y * IMG_W + x == stop_at) return;
        drive(pix(t, x, y), (x == 0 && y == 0), expv(et, x, y), (x == 0 && y == 0),
              (x == IMG_W - 1));
        if (gaps) idle(1);
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    i_valid = 1'b0;
    i_sof   = 1'b0;
    i_data  = 12'h000;
`ifdef MEDIAN_BYPASS_EN
    i_bypass = 1'b0;
`endif
    do_reset();
    frame(1, 1, 1'b0, -1);
    frame(2, 2, 1'b0, -1);
    frame(3, 3, 1'b0, -1);
    frame(4, 4, 1'b0, -1);
    frame(1, 1, 1'b1, 20);
    do_reset();
    frame(1, 1, 1'b0, -1);
`ifdef MEDIAN_BYPASS_EN
    idle(1);
    i_bypass = 1'b1;
    frame(2, 6, 1'b0, -1);
    idle(1);
    i_bypass = 1'b0;
    frame(2, 2, 1'b0, -1);
`endif
    idle(1);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    check("drain", q.size(), 0);
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
